bcd_2_binary: RTL and testbench
===============================

Name: bcd_2_binary

Overview:
- Multi-cycle BCD-to-binary converter using reverse double-dabble: one bit per clock, shift right, then subtract 3 from every BCD digit that is >= 8.
- Inverse of the existing binary-to-BCD path. Converts decimal values entered on the 7-segment/keypad or UART front end into binary operands, for example MD5 search-range bounds and counters.
- Start/valid handshake. Result is held until the next conversion.

Parameters:
- DIGITS, 7, number of packed BCD digits on the input (4*DIGITS bits).
- BIN_W, 36, output binary width and the iteration count. Must satisfy 2^BIN_W > 10^DIGITS - 1. For the default of 7 digits the minimum is 24.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; honoured only in S_IDLE.
- bcd  in  4*DIGITS  packed BCD, digit 0 in [3:0]; sampled on the edge that accepts start.
- busy  out  1  high from the accepting edge until the valid cycle ends.
- valid  out  1  one-cycle pulse; binary is correct while it is high.
- binary  out  BIN_W  converted value, held until the next valid.
- bcd_err  out  1  invalid-digit flag; present only with BCD_CHECK_EN.

Behaviour:
- Reset (reset_n low at an edge): state S_IDLE, busy=0, valid=0, binary=0, bcd_err=0, iteration counter=0, work register cleared.
- Reset has priority over every other event, including mid-conversion. Any in-flight conversion is discarded and no valid is produced.
- Work register R is 4*DIGITS+BIN_W bits wide: {bcd_field, bin_field}.
- State S_IDLE:
  - start=1 → load R={bcd, BIN_W'b0}, cnt=0, busy=1, go to S_SHIFT.
  - start=0 → remain in S_IDLE.
- State S_SHIFT, each cycle:
  - R = R >> 1 (logical, zero fill at the MSB).
  - Then, for every 4-bit digit of bcd_field: digit >= 8 → digit - 3, otherwise unchanged. All digits are evaluated in parallel on the post-shift value.
  - cnt increments.
  - When cnt == BIN_W-1 this cycle: binary <= bin_field of the post-iteration value, valid <= 1, go to S_DONE.
- State S_DONE: valid <= 0, busy <= 0, go to S_IDLE. valid is therefore high for exactly one cycle.
- Latency: start accepted at edge 0; valid is high in the cycle after edge BIN_W (36 cycles for the default). Back-to-back throughput is one conversion per BIN_W+2 cycles.
- start while busy (S_SHIFT or S_DONE) is ignored. No queuing and no effect on the running result.
- start in the same cycle valid is high is also ignored; the next start is accepted in S_IDLE.
- bcd may change after the accepting edge without affecting the result.
- binary is zero-extended; upper bits beyond ceil(log2(10^DIGITS)) read 0.
- Invalid digits (>9) without checking: the output is deterministic but meaningless, and there is no flag.

Optional Feature:
- Macro BCD_CHECK_EN.
- When defined:
  - At the accepting edge, each input digit is compared against 9.
  - bcd_err is registered to 1 if any digit exceeds 9, else 0.
  - The conversion still runs; valid still pulses and binary holds the raw iteration result.
  - bcd_err holds its value until the next accepted start or reset.
- When undefined: the bcd_err port and the comparators are absent.

Decomposition:
- Package bcd_pkg:
  - state enum {S_IDLE, S_SHIFT, S_DONE};
  - localparams BCD_DIGIT_W=4, DEFAULT_DIGITS=7, DEFAULT_BIN_W=36;
  - constant function for the minimum BIN_W from DIGITS (used in an elaboration-time assertion).
- One sub-module, bcd_digit_sub3: combinational 4-bit, out = (in >= 8) ? in - 3 : in. Instantiated DIGITS times via generate.

Test Plan:
- Reset, then start with bcd=28'h0000000 → valid one cycle at start+36 with binary=36'h0; busy high for exactly 37 cycles.
- bcd=28'h9999999 → binary=36'h00098967F (9,999,999).
- bcd=28'h1234567 → binary=36'h00012D687 (1,234,567). Then, 2 cycles after valid, start with bcd=28'h0000001 → binary=1.
- Start 28'h0000042, then pulse start with 28'h0000099 at cycles +5 and +36 (the valid cycle) → only binary=36'h2A is produced; no second valid follows.
- Start 28'h7654321, drive reset_n low at cycle +10 for one cycle → valid never pulses, binary=0, busy=0; a fresh start afterwards returns 36'h74CBB1.
- With BCD_CHECK_EN, bcd=28'h000000A → bcd_err=1 from the cycle after acceptance. A subsequent bcd=28'h0000009 → bcd_err=0 and binary=9.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } bcd_state_e;

   localparam int BCD_DIGIT_W    = 4;
   localparam int DEFAULT_DIGITS = 7;
   localparam int DEFAULT_BIN_W  = 36;

   // Smallest width w such that 2^w covers every value up to 10^digits - 1.
   function automatic int min_bin_w(input int digits);
      longint lim;
      int     w;
      lim = 1;
      w   = 0;
      for (int i = 0; i < digits; i++) lim = lim * 10;
      while ((longint'(1) << w) < lim) w++;
      return w;
   endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// One reverse double-dabble correction: a digit of 8 or more loses 3.
module bcd_digit_sub3 (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd8) digit_o = digit_i - 4'd3;
   end

endmodule

// File: rtl/bcd_2_binary.sv
// Multi-cycle BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Optional macro BCD_CHECK_EN adds the registered bcd_err invalid-digit flag.
module bcd_2_binary
   import bcd_pkg::*;
#(
   parameter int DIGITS = DEFAULT_DIGITS,
   parameter int BIN_W  = DEFAULT_BIN_W
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic                          busy,
   output logic                          valid,
   output logic [BIN_W-1:0]              binary
`ifdef BCD_CHECK_EN
   ,
   output logic                          bcd_err
`endif
);

   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int R_W   = BCD_W + BIN_W;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_bin_w
      $error("bcd_2_binary: BIN_W too small for DIGITS");
   end

   bcd_state_e       state_q, state_d;
   logic [R_W-1:0]   r_q, r_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [BIN_W-1:0] binary_q, binary_d;

   logic [R_W-1:0]   r_shift;
   logic [R_W-1:0]   r_adj;

   // Shift first, then correct every BCD digit in parallel on the shifted value.
   assign r_shift = r_q >> 1;
   assign r_adj[BIN_W-1:0] = r_shift[BIN_W-1:0];

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_sub3 u_sub3 (
         .digit_i (r_shift[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
         .digit_o (r_adj  [BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W])
      );
   end

`ifdef BCD_CHECK_EN
   logic             err_q, err_d;
   logic [DIGITS-1:0] digit_bad;

   for (genvar i = 0; i < DIGITS; i++) begin : g_check
      assign digit_bad[i] = (bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W] > 4'd9);
   end
`endif

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      valid_d  = 1'b0;
      binary_d = binary_q;
`ifdef BCD_CHECK_EN
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               r_d     = {bcd, {BIN_W{1'b0}}};
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_SHIFT;
`ifdef BCD_CHECK_EN
               err_d   = |digit_bad;
`endif
            end
         end
         S_SHIFT: begin
            r_d = r_adj;
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               binary_d = r_adj[BIN_W-1:0];
               valid_d  = 1'b1;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         r_q      <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         binary_q <= '0;
`ifdef BCD_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         binary_q <= binary_d;
`ifdef BCD_CHECK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign busy   = busy_q;
   assign valid  = valid_q;
   assign binary = binary_q;
`ifdef BCD_CHECK_EN
   assign bcd_err = err_q;
`endif

endmodule

// File: tb/tb_bcd_2_binary.sv
// Self-checking bench for bcd_2_binary: vector table, corner sequences, random vs. decimal model.
module tb_bcd_2_binary;

   localparam int DIGITS = 7;
   localparam int BIN_W  = 36;
   localparam int WIN    = BIN_W + 12;

   logic                clk;
   logic                reset_n;
   logic                start;
   logic [4*DIGITS-1:0] bcd;
   logic                busy;
   logic                valid;
   logic [BIN_W-1:0]    binary;
`ifdef BCD_CHECK_EN
   logic                bcd_err;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   bcd_2_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .bcd     (bcd),
      .busy    (busy),
      .valid   (valid),
      .binary  (binary)
`ifdef BCD_CHECK_EN
      ,
      .bcd_err (bcd_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4*DIGITS-1:0] bcd;
      logic [BIN_W-1:0]    exp;
   } vec_t;

   task automatic check(input string name, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Decimal model: plain positional arithmetic over the packed digits.
   function automatic longint bcd_value(input logic [4*DIGITS-1:0] b);
      longint v;
      logic [4*DIGITS-1:0] t;
      v = 0;
      t = b;
      for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + longint'(t[4*i +: 4]);
      return v;
   endfunction

   // Starts one conversion and watches a window of iterations; iteration k is the
   // falling edge after accepting-edge-relative rising edge k.
   task automatic conv(input logic [4*DIGITS-1:0] b, input int pa, input int pb,
                       input int rst_at, input int win,
                       output logic [BIN_W-1:0] res, output int lat,
                       output int nvalid, output int bcnt, output logic err0);
      lat    = -1;
      nvalid = 0;
      bcnt   = 0;
      res    = '0;
      err0   = 1'b0;
      start  = 1'b1;
      bcd    = b;
      for (int k = 0; k < win; k++) begin
         @(negedge clk);
         start   = 1'b0;
         reset_n = 1'b1;
         bcd     = 28'($urandom);
         if (busy) bcnt++;
         if (valid) begin
            if (lat < 0) begin
               lat = k;
               res = binary;
            end
            nvalid++;
         end
`ifdef BCD_CHECK_EN
         if (k == 0) err0 = bcd_err;
`endif
         if (k == pa || k == pb) begin
            start = 1'b1;
            bcd   = 28'h0000099;
         end
         if (k == rst_at) reset_n = 1'b0;
      end
   endtask

   vec_t vecs[6];
   logic [BIN_W-1:0] res;
   int lat, nvalid, bcnt;
   logic err0;

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      bcd     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy",   busy,   0);
      check("reset_valid",  valid,  0);
      check("reset_binary", binary, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Zero input: latency, busy span, single valid pulse.
      conv(28'h0000000, -1, -1, -1, WIN, res, lat, nvalid, bcnt, err0);
      check("zero_binary", res, 0);
      check("zero_latency", lat, BIN_W);
      check("zero_busy_cycles", bcnt, BIN_W + 1);
      check("zero_valid_pulses", nvalid, 1);

      vecs[0] = '{28'h9999999, 36'h00098967F};
      vecs[1] = '{28'h0000001, 36'h000000001};
      vecs[2] = '{28'h0000010, 36'h00000000A};
      vecs[3] = '{28'h8000000, 36'h0007A1200};
      vecs[4] = '{28'h0000099, 36'h000000063};
      vecs[5] = '{28'h1000000, 36'h0000F4240};
      for (int i = 0; i < 6; i++) begin
         conv(vecs[i].bcd, -1, -1, -1, BIN_W + 2, res, lat, nvalid, bcnt, err0);
         check($sformatf("vec%0d_binary", i), res, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), lat, BIN_W);
      end

      // Back-to-back: next start two cycles after valid.
      conv(28'h1234567, -1, -1, -1, BIN_W + 2, res, lat, nvalid, bcnt, err0);
      check("b2b_first", res, 36'h00012D687);
      conv(28'h0000001, -1, -1, -1, WIN, res, lat, nvalid, bcnt, err0);
      check("b2b_second", res, 1);
      check("b2b_second_latency", lat, BIN_W);

      // Starts while busy and during the valid cycle are ignored.
      conv(28'h0000042, 5, BIN_W, -1, WIN + 40, res, lat, nvalid, bcnt, err0);
      check("ignore_binary", res, 36'h2A);
      check("ignore_valid_pulses", nvalid, 1);
      check("ignore_binary_held", binary, 36'h2A);
      check("ignore_busy_end", busy, 0);

      // Reset mid-conversion discards the result.
      conv(28'h7654321, -1, -1, 10, WIN, res, lat, nvalid, bcnt, err0);
      check("rst_valid_pulses", nvalid, 0);
      check("rst_binary", binary, 0);
      check("rst_busy", busy, 0);
      conv(28'h7654321, -1, -1, -1, WIN, res, lat, nvalid, bcnt, err0);
      check("rst_fresh", res, 36'h74CBB1);

`ifdef BCD_CHECK_EN
      conv(28'h000000A, -1, -1, -1, WIN, res, lat, nvalid, bcnt, err0);
      check("err_set", err0, 1);
      check("err_held", bcd_err, 1);
      conv(28'h0000009, -1, -1, -1, WIN, res, lat, nvalid, bcnt, err0);
      check("err_clear", err0, 0);
      check("err_clear_binary", res, 9);
`endif

      // Random legal BCD against the decimal model.
      for (int n = 0; n < 20; n++) begin
         logic [4*DIGITS-1:0] b;
         for (int d = 0; d < DIGITS; d++) b[4*d +: 4] = 4'($urandom_range(0, 9));
         conv(b, -1, -1, -1, BIN_W + 2, res, lat, nvalid, bcnt, err0);
         check($sformatf("rand%0d_%07h", n, b), res, bcd_value(b));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1, "timeout");
   end

endmodule
